// File: rtl/dmac_multi_ch.sv
// dmac_multi_ch: multi-channel memory-to-memory DMA with round-robin per burst.
// Optional per-channel abort port is built when DMAC_ABORT_EN is defined.
module dmac_multi_ch #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH*ADDR_W-1:0] src_addr,
  input  logic [NUM_CH*ADDR_W-1:0] dst_addr,
  input  logic [NUM_CH*LEN_W-1:0]  transfer_length,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_ack,
  input  logic                     rd_valid,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     wr_req,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_ack
`ifdef DMAC_ABORT_EN
  ,
  input  logic [NUM_CH-1:0]        abort
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_NEXT
  } state_t;

  state_t state_q, state_d;
  logic [CH_W-1:0] gnt_q, gnt_d;
  logic [CH_W-1:0] rr_q, rr_d;
  logic [BC_W-1:0] bcnt_q, bcnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] src_q, src_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] dst_q, dst_d;
  logic [NUM_CH-1:0][LEN_W-1:0] len_q, len_d;
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] abt_q, abt_d;

  logic [NUM_CH-1:0] abt_v;
  logic [NUM_CH-1:0] cand;
  logic act;
  logic found;
  logic kill;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] idx;

`ifdef DMAC_ABORT_EN
  assign abt_v = abort & busy_q;
`else
  assign abt_v = '0;
`endif

  // State register; every flop cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      abt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  // Channel bookkeeping, arbitration and transfer sequencing
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    busy_d  = busy_q;
    done_d  = '0;
    abt_d   = abt_q;
    found   = 1'b0;
    kill    = 1'b0;
    sel     = '0;
    idx     = '0;
    cand    = busy_q & ~abt_v;
    act     = (state_q != S_IDLE) && (state_q != S_ARB);

    for (int i = 0; i < NUM_CH; i++) begin
      if (abt_v[i]) begin
        if (act && gnt_q == CH_W'(i)) abt_d[i] = 1'b1;
        else busy_d[i] = 1'b0;
      end
      if (start[i] && !busy_q[i]) begin
        src_d[i] = src_addr[i*ADDR_W +: ADDR_W];
        dst_d[i] = dst_addr[i*ADDR_W +: ADDR_W];
        len_d[i] = transfer_length[i*LEN_W +: LEN_W];
        if (transfer_length[i*LEN_W +: LEN_W] != '0) busy_d[i] = 1'b1;
        else done_d[i] = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (|busy_q) state_d = S_ARB;
      end
      S_ARB: begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (int'(rr_q) + k >= NUM_CH) idx = CH_W'(int'(rr_q) + k - NUM_CH);
          else idx = CH_W'(int'(rr_q) + k);
          if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = idx;
          end
        end
        if (found) begin
          gnt_d   = sel;
          rr_d    = (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
          bcnt_d  = '0;
          state_d = S_RD_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (rd_ack) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (rd_valid) begin
          data_d  = rd_data;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (wr_ack) state_d = S_NEXT;
      end
      S_NEXT: begin
        src_d[gnt_q] = src_q[gnt_q] + STEP;
        dst_d[gnt_q] = dst_q[gnt_q] + STEP;
        len_d[gnt_q] = len_q[gnt_q] - LEN_W'(1);
        bcnt_d       = bcnt_q + 1'b1;
        kill         = abt_q[gnt_q] | abt_v[gnt_q];
        if (kill) begin
          busy_d[gnt_q] = 1'b0;
          abt_d[gnt_q]  = 1'b0;
          state_d       = S_ARB;
        end else if (len_q[gnt_q] == LEN_W'(1)) begin
          busy_d[gnt_q] = 1'b0;
          done_d[gnt_q] = 1'b1;
          state_d       = S_ARB;
        end else if (bcnt_q + 1'b1 == BC_W'(BURST_LEN)) begin
          state_d = S_ARB;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_req  = (state_q == S_RD_REQ);
  assign rd_addr = src_q[gnt_q];
  assign wr_req  = (state_q == S_WR_REQ);
  assign wr_addr = dst_q[gnt_q];
  assign wr_data = data_q;

endmodule

// File: tb/tb_dmac_multi_ch.sv
// tb_dmac_multi_ch: randomized memory responder plus a round-robin job model.
// Directed cases cover single job, zero length, interleave, stalls, wrap, reset, abort.
module tb_dmac_multi_ch;
  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 16;
  localparam int BL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] start = '0;
  logic [NCH*AW-1:0] src_addr = '0;
  logic [NCH*AW-1:0] dst_addr = '0;
  logic [NCH*LW-1:0] transfer_length = '0;
  logic [NCH-1:0] busy, done;
  logic rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic rd_ack = 1'b0;
  logic rd_valid = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic wr_ack = 1'b0;
`ifdef DMAC_ABORT_EN
  logic [NCH-1:0] abort = '0;
  int abort_ch = 0;
  int abort_at = 0;
`endif

  always #5 clk = ~clk;

  dmac_multi_ch #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr),
    .transfer_length(transfer_length),
    .busy(busy), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack)
`ifdef DMAC_ABORT_EN
    , .abort(abort)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] rd_log[$];
  logic [63:0] wr_log[$];
  logic [31:0] exp_rd[$];
  logic [63:0] exp_wr[$];
  int done_cnt[NCH];
  int model_rr = 0;
  logic [31:0] j_src[NCH];
  logic [31:0] j_dst[NCH];
  logic [15:0] j_len[NCH];

  bit fixed = 1'b1;
  int rd_dly = 0;
  int wr_dly = 0;

  // Memory fabric responder, acting on the falling edge
  initial begin
    int rd_seen, rd_tgt, wr_seen, wr_tgt, vcnt;
    bit rd_phase;
    logic [31:0] rd_hold, ra_lat, wa_hold, wd_hold;
    rd_seen = 0; rd_tgt = 0; wr_seen = 0; wr_tgt = 0;
    vcnt = 0; rd_phase = 0;
    rd_hold = '0; ra_lat = '0; wa_hold = '0; wd_hold = '0;
    forever begin
      @(negedge clk);
      rd_ack = 1'b0;
      rd_valid = 1'b0;
      wr_ack = 1'b0;
`ifdef DMAC_ABORT_EN
      abort = '0;
`endif
      if (rst) begin
        rd_phase = 0; rd_seen = 0; wr_seen = 0;
        continue;
      end
      for (int c = 0; c < NCH; c++) if (done[c]) done_cnt[c]++;
      if (rd_phase) begin
        if (vcnt == 0) begin
          rd_valid = 1'b1;
          rd_data = mem_f(ra_lat);
          rd_phase = 0;
        end else vcnt--;
      end else if (rd_req) begin
        if (rd_seen == 0) begin
          rd_tgt = fixed ? rd_dly : int'($urandom_range(0, 3));
          rd_hold = rd_addr;
        end else check("rd_addr_hold", rd_addr, rd_hold);
        if (rd_seen == rd_tgt) begin
          rd_ack = 1'b1;
          rd_log.push_back(rd_addr);
          ra_lat = rd_addr;
          rd_phase = 1;
          vcnt = fixed ? 0 : int'($urandom_range(0, 2));
          rd_seen = 0;
        end else rd_seen++;
      end
      if (wr_req) begin
        if (wr_seen == 0) begin
          wr_tgt = fixed ? wr_dly : int'($urandom_range(0, 3));
          wa_hold = wr_addr;
          wd_hold = wr_data;
        end else begin
          check("wr_addr_hold", wr_addr, wa_hold);
          check("wr_data_hold", wr_data, wd_hold);
        end
        if (wr_seen == wr_tgt) begin
          wr_ack = 1'b1;
          wr_log.push_back({wr_addr, wr_data});
          wr_seen = 0;
`ifdef DMAC_ABORT_EN
          if (abort_at != 0 && wr_log.size() == abort_at)
            abort[abort_ch] = 1'b1;
`endif
        end else wr_seen++;
      end
    end
  end

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete();
    exp_rd.delete(); exp_wr.delete();
    for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
  endtask

  task automatic drive_cfg();
    for (int c = 0; c < NCH; c++) begin
      src_addr[c*AW +: AW] = j_src[c];
      dst_addr[c*AW +: AW] = j_dst[c];
      transfer_length[c*LW +: LW] = j_len[c];
    end
  endtask

  // Expected traffic: round-robin over channels, at most BL words per grant
  task automatic model_jobs(input logic [NCH-1:0] m);
    int rem[NCH];
    int off[NCH];
    int c, n;
    logic [31:0] a;
    for (int i = 0; i < NCH; i++) begin
      rem[i] = m[i] ? int'(j_len[i]) : 0;
      off[i] = 0;
    end
    for (int g = 0; g < 1000; g++) begin
      c = -1;
      for (int k = 0; k < NCH; k++)
        if (c < 0 && rem[(model_rr + k) % NCH] > 0) c = (model_rr + k) % NCH;
      if (c < 0) break;
      n = (rem[c] < BL) ? rem[c] : BL;
      for (int w = 0; w < n; w++) begin
        a = j_src[c] + 32'(4 * off[c]);
        exp_rd.push_back(a);
        exp_wr.push_back({j_dst[c] + 32'(4 * off[c]), mem_f(a)});
        off[c]++;
      end
      rem[c] -= n;
      model_rr = (c + 1) % NCH;
    end
  endtask

  task automatic kick(input logic [NCH-1:0] m);
    drive_cfg();
    @(negedge clk);
    start = m;
    @(negedge clk);
    start = '0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy != '0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check({tag, "_timeout"}, 64'(t >= 4000), 0);
  endtask

  task automatic run(input logic [NCH-1:0] m, input string tag);
    clear_logs();
    model_jobs(m);
    kick(m);
    wait_idle(tag);
    for (int c = 0; c < NCH; c++)
      check({tag, "_done_cnt"}, done_cnt[c], 64'(m[c] && j_len[c] != 0 ? 1 : m[c]));
    check({tag, "_busy"}, busy, 0);
    check({tag, "_n_rd"}, rd_log.size(), exp_rd.size());
    check({tag, "_n_wr"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      check({tag, "_rd"}, rd_log[i], exp_rd[i]);
      check({tag, "_wr"}, wr_log[i], exp_wr[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
  endtask

  initial begin
    int runs[$];
    int exp_runs[5];
    int cur, cnt, ch, t;
    logic [NCH-1:0] m;
    exp_runs = '{4, 20, 4, 18, 2};
    for (int c = 0; c < NCH; c++) begin
      j_src[c] = '0; j_dst[c] = '0; j_len[c] = '0;
    end

    repeat (3) @(negedge clk);
    check("reset_outs", {rd_req, wr_req, busy, done, rd_addr, wr_addr}, 0);
    check("reset_wdata", wr_data, 0);
    rst = 1'b0;

    // single channel, 3 words
    j_src[0] = 32'h0; j_dst[0] = 32'h22EFC; j_len[0] = 16'd3;
    run(3'b001, "t1");
    check("t1_rd2", rd_log[2], 32'h8);
    check("t1_wa1", wr_log[1][63:32], 32'h22F00);
    check("t1_wa2", wr_log[2][63:32], 32'h22F04);

    // zero length job
    clear_logs();
    j_len[1] = 16'd0; j_src[1] = 32'h40;
    drive_cfg();
    @(negedge clk);
    start = 3'b010;
    @(negedge clk);
    start = '0;
    check("t2_done", done, 3'b010);
    check("t2_busy", busy, 0);
    @(negedge clk);
    check("t2_done_clr", done, 0);
    repeat (3) @(negedge clk);
    check("t2_no_bus", rd_log.size() + wr_log.size(), 0);

    // two channels interleaving at burst granularity
    do_reset();
    j_src[0] = 32'h100; j_dst[0] = 32'h1000_0000; j_len[0] = 16'd10;
    j_src[1] = 32'h800; j_dst[1] = 32'h2000_0000; j_len[1] = 16'd6;
    run(3'b011, "t3");
    cur = -1; cnt = 0;
    foreach (wr_log[i]) begin
      ch = (wr_log[i][63:60] == 4'h2) ? 1 : 0;
      if (ch == cur) cnt++;
      else begin
        if (cur >= 0) runs.push_back(cur * 16 + cnt);
        cur = ch; cnt = 1;
      end
    end
    if (cur >= 0) runs.push_back(cur * 16 + cnt);
    check("t3_nruns", runs.size(), 5);
    for (int i = 0; i < 5; i++) check("t3_run", runs[i], exp_runs[i]);

    // long ack stalls
    rd_dly = 5; wr_dly = 3;
    j_src[2] = 32'h3000; j_dst[2] = 32'h4000; j_len[2] = 16'd3;
    run(3'b100, "t4");
    rd_dly = 0; wr_dly = 0;

    // address wrap
    j_src[1] = 32'hFFFF_FFFC; j_dst[1] = 32'h5000; j_len[1] = 16'd2;
    run(3'b010, "t5");
    check("t5_wrap", rd_log[1], 32'h0);

    // reset in the middle of a transfer
    clear_logs();
    j_src[0] = 32'h700; j_dst[0] = 32'h9000; j_len[0] = 16'd8;
    kick(3'b001);
    t = 0;
    while (wr_log.size() < 2 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("t6_progress", 64'(t >= 2000), 0);
    rst = 1'b1;
    #1;
    check("t6_rst_outs", {rd_req, wr_req, busy, done, rd_addr, wr_addr}, 0);
    check("t6_rst_wdata", wr_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
    j_len[0] = 16'd5;
    run(3'b001, "t6");

    // randomized job mixes
    fixed = 1'b0;
    for (int n = 0; n < 25; n++) begin
      m = NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        j_len[c] = 16'($urandom_range(0, 9));
        j_src[c] = $urandom & 32'hFFFF_FFFC;
        j_dst[c] = $urandom & 32'hFFFF_FFFC;
      end
      run(m, "rnd");
    end
    fixed = 1'b1;

`ifdef DMAC_ABORT_EN
    // abort the active channel after two words
    do_reset();
    clear_logs();
    j_src[0] = 32'h100; j_dst[0] = 32'h200; j_len[0] = 16'd6;
    abort_ch = 0; abort_at = 2;
    kick(3'b001);
    wait_idle("ab0");
    check("ab0_n_wr", wr_log.size(), 2);
    check("ab0_done", done_cnt[0], 0);
    check("ab0_busy", busy, 0);

    // abort a pending channel while another runs
    do_reset();
    clear_logs();
    j_len[0] = 16'd6;
    j_src[1] = 32'h900; j_dst[1] = 32'hA00; j_len[1] = 16'd4;
    abort_ch = 1; abort_at = 1;
    kick(3'b011);
    wait_idle("ab1");
    abort_at = 0;
    check("ab1_n_wr", wr_log.size(), 6);
    check("ab1_done0", done_cnt[0], 1);
    check("ab1_done1", done_cnt[1], 0);
    check("ab1_busy", busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
